// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: register-mapped control block for the UART receiver.
// It holds the baud divisor and the enable/interrupt controls, buffers bytes
// from uart_rx in a small FIFO and raises a level interrupt.
// Register map: 0 DATA (read pops), 1 STATUS, 2 BAUD_LO, 3 BAUD_HI.
// Optional receive-idle timeout: define UART_RX_TIMEOUT_EN to build the
// bit-tick prescaler and idle counter that drive STATUS[6].
module uart_rx_ctrl #(
  parameter int          FIFO_AW    = 4,
  parameter logic [15:0] BAUD_RESET = 16'd216
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic [15:0] baudrate_div,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        irq
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};

  localparam logic [1:0] A_DATA    = 2'd0;
  localparam logic [1:0] A_STATUS  = 2'd1;
  localparam logic [1:0] A_BAUD_LO = 2'd2;
  localparam logic [1:0] A_BAUD_HI = 2'd3;

  // STATUS bit positions
  localparam int S_OVERRUN = 2;
  localparam int S_ENABLE  = 3;
  localparam int S_FLUSH   = 4;
  localparam int S_IRQ_EN  = 5;
  localparam int S_TIMEOUT = 6;

  // FIFO storage (no reset; contents are don't-care after reset)
  logic [7:0] mem [DEPTH];

  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;

  logic        overrun_q, overrun_d;
  logic        enable_q, enable_d;
  logic        irq_en_q, irq_en_d;
  logic [15:0] baud_q, baud_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        irq_q, irq_d;

  logic        timeout_flag;

  // Decoded strobes and FIFO conditions
  logic wr_status;
  logic fifo_empty;
  logic fifo_full;
  logic flush;
  logic pop;
  logic push_req;
  logic push;
  logic overflow;
  logic [7:0] status_val;

  assign wr_status  = wr_en && (addr == A_STATUS);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_COUNT);
  assign flush      = wr_status && wr_data[S_FLUSH];
  assign pop        = rd_en && (addr == A_DATA) && !fifo_empty;
  assign push_req   = rx_valid && enable_q;
  // A full FIFO still accepts a byte when the same cycle frees a slot.
  // Flush beats a concurrent push: the byte is lost without an overrun.
  assign push       = push_req && (!fifo_full || pop) && !flush;
  assign overflow   = push_req && fifo_full && !pop && !flush;

  assign status_val = {1'b0, timeout_flag, irq_en_q, 1'b0,
                       enable_q, overrun_q, fifo_full, !fifo_empty};

`ifdef UART_RX_TIMEOUT_EN
  // Receive-idle timeout: 40 bit ticks (about 4 characters) with data waiting
  localparam logic [5:0] IDLE_LIMIT = 6'd40;

  logic [15:0] pre_q, pre_d;
  logic [5:0]  idle_q, idle_d;
  logic        timeout_q, timeout_d;
  logic        tick;
  logic        idle_clr;

  assign tick     = (pre_q >= baud_q);
  assign idle_clr = push || pop || flush || fifo_empty;

  // Prescaler, idle counter and sticky timeout flag next-state
  always_comb begin
    pre_d     = tick ? 16'd0 : pre_q + 16'd1;
    idle_d    = idle_q;
    timeout_d = timeout_q;
    if (wr_status && wr_data[S_TIMEOUT]) begin
      timeout_d = 1'b0;
    end
    if (idle_clr) begin
      idle_d = 6'd0;
    end else if (tick && (idle_q != IDLE_LIMIT)) begin
      idle_d = idle_q + 6'd1;
      // set only on the step into the limit so a clear stays cleared
      if (idle_q == IDLE_LIMIT - 6'd1) begin
        timeout_d = 1'b1;
      end
    end
  end

  // Timeout state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= 16'd0;
      idle_q    <= 6'd0;
      timeout_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0;
`endif

  // Bits of wr_data that no register implements in some builds
  logic unused_wr_bits;
  assign unused_wr_bits = ^{wr_data[7:6]};

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers, baud divisor and sticky overrun next-state
  always_comb begin
    overrun_d = overrun_q;
    enable_d  = enable_q;
    irq_en_d  = irq_en_q;
    baud_d    = baud_q;
    if (wr_status) begin
      enable_d = wr_data[S_ENABLE];
      irq_en_d = wr_data[S_IRQ_EN];
      if (wr_data[S_OVERRUN]) begin
        overrun_d = 1'b0;
      end
    end
    // a new overflow wins over a same-cycle clear
    if (overflow) begin
      overrun_d = 1'b1;
    end
    if (wr_en && (addr == A_BAUD_LO)) begin
      baud_d[7:0] = wr_data;
    end
    if (wr_en && (addr == A_BAUD_HI)) begin
      baud_d[15:8] = wr_data;
    end
  end

  // Read mux: captures pre-write state and holds until the next read
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      case (addr)
        A_DATA:    rd_data_d = fifo_empty ? 8'h00 : mem[rd_ptr_q];
        A_STATUS:  rd_data_d = status_val;
        A_BAUD_LO: rd_data_d = baud_q[7:0];
        default:   rd_data_d = baud_q[15:8];
      endcase
    end
  end

  // Interrupt from current state; lands one cycle after its sources
  always_comb begin
    irq_d = irq_en_q && (!fifo_empty || overrun_q || timeout_flag);
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= rx_data;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      enable_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      baud_q    <= BAUD_RESET;
      rd_data_q <= 8'h00;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      enable_q  <= enable_d;
      irq_en_q  <= irq_en_d;
      baud_q    <= baud_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign baudrate_div = baud_q;
  assign irq          = irq_q;

endmodule
